arm_ctrl: RTL

Fetch/execute sequencer for the 16-bit Harvard core. It is the initiator side of the ALU's inst/state interface.
- Fetches instructions from instruction memory over a req/ack handshake and holds them in an instruction register.
- Drives the one-hot phase bus (FETCH/EXEC1/EXEC2) and `inst` consumed by the ALU and writeback logic.
- Owns the PC, jumps/branches, and the zero flag sampled from writeback.

---
 rtl/arm_pkg.sv | 30 +++
 rtl/arm_ctrl_if.sv | 23 ++
 rtl/arm_pc_next.sv | 41 ++++
 rtl/arm_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the arm_ctrl fetch/execute sequencer.
// Optional feature macro: ARM_CTRL_HALT_EN (enables the HALT state).
package arm_pkg;

    // One-hot phase encodings; ST_HALT is all-zero and only reachable with HALT enabled
    typedef enum logic [2:0] {
        ST_HALT  = 3'b000,
        ST_FETCH = 3'b001,
        ST_EXEC1 = 3'b010,
        ST_EXEC2 = 3'b100
    } state_e;

    // Instruction classes, decoded from inst[15:13] when inst[15]=0
    localparam logic [2:0] CLS_JMP = 3'b000;
    localparam logic [2:0] CLS_LI  = 3'b001;
    localparam logic [2:0] CLS_BZ  = 3'b010;
    localparam logic [2:0] CLS_RSV = 3'b011;

    localparam logic [3:0] OP_LDR  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b0111;

    function automatic logic is_ldr(input logic [15:0] ins);
        return ins[15:12] == OP_LDR;
    endfunction

    function automatic logic is_halt(input logic [15:0] ins);
        return ins[15:12] == OP_HALT;
    endfunction

endpackage

// File: rtl/arm_ctrl_if.sv
// Instruction-memory fetch handshake between arm_ctrl (master) and imem (slave).
interface arm_ctrl_if #(
    parameter int unsigned AW = 8
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_data;
    logic          imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output imem_ack
    );
endinterface

// File: rtl/arm_pc_next.sv
// Combinational next-PC logic: fetch increment, JMP target and BZ relative branch.
module arm_pc_next
    import arm_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic [AW-1:0] pc,
    input  logic [15:0]   inst,
    input  logic          zflag,
    input  logic [2:0]    phase,
    input  logic          imem_ack,
    output logic [AW-1:0] pc_next
);

    logic [15:0] br_off;
    logic        unused_bits;

    assign br_off = {{8{inst[7]}}, inst[7:0]};
    // Only a subset of the opcode/offset bits matter for a given AW
    assign unused_bits = ^{inst, br_off};

    // Select next PC from the current phase and the instruction class
    always_comb begin
        pc_next = pc;
        if (phase == ST_FETCH) begin
            if (imem_ack) begin
                pc_next = pc + AW'(1);
            end
        end else if (phase == ST_EXEC1 && !inst[15]) begin
            case (inst[15:13])
                CLS_JMP: pc_next = inst[AW-1:0];
                // pc already points past the branch; offset wraps mod 2^AW
                CLS_BZ:  pc_next = zflag ? (pc + br_off[AW-1:0]) : pc;
                CLS_LI:  pc_next = pc;
                CLS_RSV: pc_next = pc;
                default: pc_next = pc;
            endcase
        end
    end

endmodule

// File: rtl/arm_ctrl.sv
// Fetch/execute sequencer for the 16-bit Harvard core: owns PC, instruction register,
// one-hot phase bus and zero flag.
// Optional feature macro: ARM_CTRL_HALT_EN (opcode 0111 halts until reset).
module arm_ctrl
    import arm_pkg::*;
#(
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    arm_ctrl_if.master    imem,
    input  logic          dmem_ack,
    input  logic          wb_en,
    input  logic [15:0]   wb_data,
    output logic [15:0]   inst,
    output logic [2:0]    state,
    output logic [AW-1:0] pc,
    output logic          zflag
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   inst_q, inst_d;
    logic          zflag_q, zflag_d;

    arm_pc_next #(
        .AW (AW)
    ) u_pc_next (
        .pc       (pc_q),
        .inst     (inst_q),
        .zflag    (zflag_q),
        .phase    (state_q),
        .imem_ack (imem.imem_ack),
        .pc_next  (pc_d)
    );

    // Phase sequencing and instruction register capture
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        case (state_q)
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    inst_d  = imem.imem_data;
                    state_d = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                if (is_ldr(inst_q)) begin
                    state_d = ST_EXEC2;
`ifdef ARM_CTRL_HALT_EN
                end else if (is_halt(inst_q)) begin
                    state_d = ST_HALT;
`endif
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC2: begin
                if (dmem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
`ifdef ARM_CTRL_HALT_EN
                state_d = ST_HALT;
`else
                state_d = ST_FETCH;
`endif
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Zero flag tracks every writeback; BZ sees the value registered before its EXEC1 edge
    always_comb begin
        zflag_d = zflag_q;
        if (wb_en) begin
            zflag_d = (wb_data == 16'h0000);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= 16'h0000;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            zflag_q <= zflag_d;
        end
    end

    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign inst           = inst_q;
    assign state          = state_q;
    assign pc             = pc_q;
    assign zflag          = zflag_q;

endmodule
